// File: rtl/aes_req_pkg.sv
// Shared types and constants for the AES request queue.
// Optional feature macro: AES_KEY_AUTOLOAD_EN (adds the automatic key-load states).
package aes_req_pkg;

  localparam logic [2:0] FUNC_DEC = 3'h0;
  localparam logic [2:0] FUNC_ENC = 3'h1;
  localparam logic [2:0] FUNC_KEY = 3'h2;

  typedef struct packed {
    logic [2:0]   func;
    logic [127:0] text;
    logic [127:0] key;
  } req_t;

`ifdef AES_KEY_AUTOLOAD_EN
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ISSUE_KEY,
    WAIT_KEY
  } aes_state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } aes_state_e;
`endif

  // Only decrypt, encrypt and key-load are meaningful to aes_build.
  function automatic logic func_legal(input logic [2:0] func);
    return (func == FUNC_DEC) || (func == FUNC_ENC) || (func == FUNC_KEY);
  endfunction

  // Data operations depend on an expanded key; key loads do not.
  function automatic logic func_uses_key(input logic [2:0] func);
    return (func == FUNC_DEC) || (func == FUNC_ENC);
  endfunction

endpackage

// File: rtl/aes_req_fifo.sv
// Circular buffer of AES requests with occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module aes_req_fifo
  import aes_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     eph1,
  input  logic                     reset,
  input  logic                     push,
  input  req_t                     din,
  input  logic                     pop,
  output req_t                     head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge eph1) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_req_queue.sv
// Request buffer and sequencer in front of aes_build: queues requests and
// issues them one at a time, waiting for call completion between issues.
// Optional feature macro: AES_KEY_AUTOLOAD_EN inserts a key-load call
// whenever a data request needs a key other than the one last loaded.
module aes_req_queue
  import aes_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   eph1,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_func,
  input  logic [127:0]           req_text,
  input  logic [127:0]           req_key,
  output logic [2:0]             aes_func,
  output logic [127:0]           aes_text,
  output logic [127:0]           aes_key,
  output logic                   aes_start,
  input  logic                   aes_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_illegal
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  aes_state_e state;
  aes_state_e next_state;
  req_t       head;
  req_t       din;
  logic       empty;
  logic       full;
  logic       accept;
  logic       push;
  logic       pop;
  logic       load_req;

`ifdef AES_KEY_AUTOLOAD_EN
  logic [127:0] loaded_key;
  logic         loaded_key_valid;
  logic         key_update;
  logic         eff_key_valid;
  logic [127:0] eff_key;
  logic         need_load;
  logic         load_key_call;
`endif

  // Readiness comes from the registered count only, so a full queue stays
  // not-ready even in a cycle where it pops.
  assign req_ready = (count < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign push      = accept && func_legal(req_func);
  assign pop       = (state == ISSUE);
  assign din       = '{func: req_func, text: req_text, key: req_key};
  assign busy      = (state != IDLE);

`ifdef AES_KEY_AUTOLOAD_EN
  assign aes_start = (state == ISSUE) || (state == ISSUE_KEY);

  // A completing key load (explicit or inserted) becomes the loaded key on
  // the same edge, so the next-head decision must already see it.
  assign key_update    = aes_done && (((state == WAIT) && (aes_func == FUNC_KEY)) ||
                                      (state == WAIT_KEY));
  assign eff_key_valid = key_update || loaded_key_valid;
  assign eff_key       = key_update ? aes_key : loaded_key;
  assign need_load     = func_uses_key(head.func) &&
                         (!eff_key_valid || (head.key != eff_key));
`else
  assign aes_start = (state == ISSUE);
`endif

  aes_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .eph1  (eph1),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // Sequencer state register.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; also decides when the output registers capture a call.
  always_comb begin
    next_state = state;
    load_req   = 1'b0;
`ifdef AES_KEY_AUTOLOAD_EN
    load_key_call = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
`ifdef AES_KEY_AUTOLOAD_EN
          if (need_load) begin
            next_state    = ISSUE_KEY;
            load_key_call = 1'b1;
          end else
`endif
          begin
            next_state = ISSUE;
            load_req   = 1'b1;
          end
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (aes_done) begin
          if (!empty) begin
`ifdef AES_KEY_AUTOLOAD_EN
            if (need_load) begin
              next_state    = ISSUE_KEY;
              load_key_call = 1'b1;
            end else
`endif
            begin
              next_state = ISSUE;
              load_req   = 1'b1;
            end
          end else begin
            next_state = IDLE;
          end
        end
      end
`ifdef AES_KEY_AUTOLOAD_EN
      ISSUE_KEY: begin
        next_state = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (aes_done) begin
          next_state = ISSUE;
          load_req   = 1'b1;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Call registers: captured on entry to an issue state, held until the
  // edge that sees completion.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      aes_func <= '0;
      aes_text <= '0;
      aes_key  <= '0;
    end else if (load_req) begin
      aes_func <= head.func;
      aes_text <= head.text;
      aes_key  <= head.key;
    end
`ifdef AES_KEY_AUTOLOAD_EN
    else if (load_key_call) begin
      aes_func <= FUNC_KEY;
      aes_text <= '0;
      aes_key  <= head.key;
    end
`endif
  end

  // Illegal requests are swallowed and flagged for exactly one cycle.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !func_legal(req_func);
    end
  end

`ifdef AES_KEY_AUTOLOAD_EN
  // Track the key aes_build currently holds in expanded form.
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      loaded_key       <= '0;
      loaded_key_valid <= 1'b0;
    end else if (key_update) begin
      loaded_key       <= aes_key;
      loaded_key_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_queue.sv
// Directed self-checking bench for aes_req_queue (DEPTH = 4).
// Covers AES_KEY_AUTOLOAD_EN behaviour when that macro is defined.
module tb_aes_req_queue;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         eph1;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_func;
  logic [127:0] req_text;
  logic [127:0] req_key;
  logic [2:0]   aes_func;
  logic [127:0] aes_text;
  logic [127:0] aes_key;
  logic         aes_start;
  logic         aes_done;
  logic         busy;
  logic [2:0]   count;
  logic         err_illegal;

  int tests = 0;
  int fails = 0;

  aes_req_queue #(
    .DEPTH (4)
  ) dut (
    .eph1        (eph1),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_func    (req_func),
    .req_text    (req_text),
    .req_key     (req_key),
    .aes_func    (aes_func),
    .aes_text    (aes_text),
    .aes_key     (aes_key),
    .aes_start   (aes_start),
    .aes_done    (aes_done),
    .busy        (busy),
    .count       (count),
    .err_illegal (err_illegal)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    eph1 = 1'b0;
    forever #5 eph1 = ~eph1;
  end

  function automatic logic [127:0] text_n(input int n);
    return PT ^ 128'(n);
  endfunction

  task automatic step();
    @(posedge eph1);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [2:0] func,
                                input logic [127:0] text, input logic [127:0] key);
    req_valid = valid;
    req_func  = func;
    req_text  = text;
    req_key   = key;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pulse_done();
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
  endtask

  // Directed sequence of scenarios.
  initial begin
    reset     = 1'b1;
    aes_done  = 1'b0;
    apply_stimulus(1'b0, 3'h0, '0, '0);
    repeat (2) step();

    check_output("reset_ready", 128'(req_ready), 128'(1));
    check_output("reset_start", 128'(aes_start), 128'(0));
    check_output("reset_busy",  128'(busy),      128'(0));
    check_output("reset_count", 128'(count),     128'(0));
    check_output("reset_err",   128'(err_illegal), 128'(0));
    check_output("reset_func",  128'(aes_func),  128'(0));

    reset = 1'b0;
    step();

    // Single key-load request
    apply_stimulus(1'b1, 3'h2, '0, KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    check_output("key_accept_count", 128'(count), 128'(1));
    check_output("key_accept_start", 128'(aes_start), 128'(0));
    step();
    check_output("key_issue_start", 128'(aes_start), 128'(1));
    check_output("key_issue_func",  128'(aes_func),  128'(2));
    check_output("key_issue_key",   aes_key,         KEY0);
    check_output("key_issue_busy",  128'(busy),      128'(1));
    step();
    check_output("key_wait_start", 128'(aes_start), 128'(0));
    check_output("key_wait_busy",  128'(busy),      128'(1));
    step();
    check_output("key_wait_busy2", 128'(busy),      128'(1));
    pulse_done();
    check_output("key_done_busy",  128'(busy),      128'(0));
    check_output("key_done_start", 128'(aes_start), 128'(0));

    // Fill the queue with encrypt requests while the first call is pending
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 3'h1, text_n(i), KEY0);
      step();
    end
    check_output("full_count", 128'(count),     128'(4));
    check_output("full_ready", 128'(req_ready), 128'(0));
    apply_stimulus(1'b1, 3'h1, text_n(5), KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    check_output("full_reject_count", 128'(count),     128'(4));
    check_output("full_reject_ready", 128'(req_ready), 128'(0));
    check_output("full_first_text",   aes_text,        text_n(0));
    check_output("full_first_func",   128'(aes_func),  128'(1));
    for (int i = 1; i <= 4; i++) begin
      pulse_done();
      check_output($sformatf("drain_start_%0d", i), 128'(aes_start), 128'(1));
      check_output($sformatf("drain_text_%0d", i),  aes_text,        text_n(i));
      step();
      check_output($sformatf("drain_count_%0d", i), 128'(count), 128'(4 - i));
      check_output($sformatf("drain_low_%0d", i),   128'(aes_start), 128'(0));
    end
    pulse_done();
    check_output("drain_idle_busy", 128'(busy), 128'(0));

    // Illegal function code
    apply_stimulus(1'b1, 3'h5, PT, KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    check_output("illegal_err",   128'(err_illegal), 128'(1));
    check_output("illegal_count", 128'(count),       128'(0));
    step();
    check_output("illegal_err_low", 128'(err_illegal), 128'(0));
    check_output("illegal_start",   128'(aes_start),   128'(0));
    check_output("illegal_busy",    128'(busy),        128'(0));

    // Simultaneous push and pop at count 2
    for (int i = 10; i < 13; i++) begin
      apply_stimulus(1'b1, 3'h1, text_n(i), KEY0);
      step();
    end
    apply_stimulus(1'b0, 3'h0, '0, '0);
    check_output("pp_count_before", 128'(count), 128'(2));
    check_output("pp_text_a",       aes_text,    text_n(10));
    pulse_done();
    check_output("pp_issue_b_start", 128'(aes_start), 128'(1));
    check_output("pp_issue_b_text",  aes_text,        text_n(11));
    apply_stimulus(1'b1, 3'h1, text_n(13), KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    check_output("pp_count_after", 128'(count), 128'(2));
    pulse_done();
    check_output("pp_issue_c_text", aes_text, text_n(12));
    step();
    pulse_done();
    check_output("pp_issue_d_text",  aes_text,        text_n(13));
    check_output("pp_issue_d_start", 128'(aes_start), 128'(1));
    step();
    pulse_done();
    check_output("pp_idle_busy", 128'(busy), 128'(0));

    // Asynchronous reset in WAIT with two entries queued
    for (int i = 20; i < 23; i++) begin
      apply_stimulus(1'b1, 3'h1, text_n(i), KEY0);
      step();
    end
    apply_stimulus(1'b0, 3'h0, '0, '0);
    check_output("rst_pre_count", 128'(count), 128'(2));
    check_output("rst_pre_busy",  128'(busy),  128'(1));
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_count", 128'(count),     128'(0));
    check_output("rst_busy",  128'(busy),      128'(0));
    check_output("rst_start", 128'(aes_start), 128'(0));
    check_output("rst_func",  128'(aes_func),  128'(0));
    check_output("rst_text",  aes_text,        128'(0));
    check_output("rst_key",   aes_key,         128'(0));
    check_output("rst_ready", 128'(req_ready), 128'(1));
    step();
    reset = 1'b0;
    pulse_done();
    check_output("rst_done_start", 128'(aes_start), 128'(0));
    check_output("rst_done_busy",  128'(busy),      128'(0));
    step();
    check_output("rst_late_start", 128'(aes_start), 128'(0));
    check_output("rst_late_count", 128'(count),     128'(0));

`ifdef AES_KEY_AUTOLOAD_EN
    // First decrypt after reset needs a key load first
    apply_stimulus(1'b1, 3'h0, CT, KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    step();
    check_output("auto_load_start", 128'(aes_start), 128'(1));
    check_output("auto_load_func",  128'(aes_func),  128'(2));
    check_output("auto_load_key",   aes_key,         KEY0);
    check_output("auto_load_text",  aes_text,        128'(0));
    check_output("auto_load_count", 128'(count),     128'(1));
    step();
    check_output("auto_wait_start", 128'(aes_start), 128'(0));
    pulse_done();
    check_output("auto_dec_start", 128'(aes_start), 128'(1));
    check_output("auto_dec_func",  128'(aes_func),  128'(0));
    check_output("auto_dec_text",  aes_text,        CT);
    check_output("auto_dec_key",   aes_key,         KEY0);
    step();
    pulse_done();
    check_output("auto_dec_idle", 128'(busy), 128'(0));

    // Same key: a single pulse
    apply_stimulus(1'b1, 3'h0, CT, KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    step();
    check_output("same_key_start", 128'(aes_start), 128'(1));
    check_output("same_key_func",  128'(aes_func),  128'(0));
    step();
    pulse_done();
    check_output("same_key_idle",  128'(busy),      128'(0));
    check_output("same_key_nostart", 128'(aes_start), 128'(0));

    // Key change re-inserts a load
    apply_stimulus(1'b1, 3'h1, PT, KEY1);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    step();
    check_output("new_key_load_func", 128'(aes_func), 128'(2));
    check_output("new_key_load_key",  aes_key,        KEY1);
    step();
    pulse_done();
    check_output("new_key_enc_start", 128'(aes_start), 128'(1));
    check_output("new_key_enc_func",  128'(aes_func),  128'(1));
    check_output("new_key_enc_key",   aes_key,         KEY1);
    step();
    pulse_done();
    check_output("new_key_idle", 128'(busy), 128'(0));
`else
    // Without autoload a decrypt passes straight through
    apply_stimulus(1'b1, 3'h0, CT, KEY0);
    step();
    apply_stimulus(1'b0, 3'h0, '0, '0);
    step();
    check_output("pass_dec_start", 128'(aes_start), 128'(1));
    check_output("pass_dec_func",  128'(aes_func),  128'(0));
    check_output("pass_dec_text",  aes_text,        CT);
    step();
    pulse_done();
    check_output("pass_dec_idle", 128'(busy), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_req_queue.md
# aes_req_queue

Request buffer and sequencer directly upstream of `aes_build`. It accepts AES work requests (function code, 128-bit text, 128-bit key) over a valid/ready port and holds up to `DEPTH` of them. It issues them to `aes_build` one at a time, waiting for `call_complete` before issuing the next. Optionally, it inserts a key-load call automatically whenever the requested key differs from the key last loaded.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `eph1`, in, 1: clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: queue can accept.
- `req_func`, in, 3: request function code.
- `req_text`, in, 128: plaintext or ciphertext.
- `req_key`, in, 128: key.
- `aes_func`, out, 3: function driven to `aes_build.func`.
- `aes_text`, out, 128: driven to `aes_build.text_in`.
- `aes_key`, out, 128: driven to `aes_build.true_key`.
- `aes_start`, out, 1: single-cycle issue strobe.
- `aes_done`, in, 1: from `aes_build.call_complete`.
- `busy`, out, 1: state is not IDLE.
- `count`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `err_illegal`, out, 1: one-cycle pulse when an illegal request is dropped.

## Operation
- Function codes:
  - `FUNC_DEC`=3'h0: decrypt.
  - `FUNC_ENC`=3'h1: encrypt.
  - `FUNC_KEY`=3'h2: key load/expand.
  - All other codes are illegal.
- Accept: `req_valid & req_ready` at a rising edge.
  - A legal request is pushed into the FIFO.
  - An illegal request is discarded and `err_illegal` pulses for the next cycle; the FIFO is unchanged.
- `req_ready` equals `count < DEPTH`, taken from registered `count`. A full queue is therefore not ready even in a cycle where it pops.
- Push and pop in the same cycle leave `count` unchanged. Read and write pointers wrap modulo `DEPTH`.
- FSM states: IDLE, ISSUE, WAIT, plus ISSUE_KEY and WAIT_KEY when the autoload feature is compiled in.
  - IDLE: when the FIFO is non-empty, go to ISSUE.
  - ISSUE: register the head entry onto `aes_func`/`aes_text`/`aes_key`, assert `aes_start` for this one cycle, pop the head, go to WAIT.
  - WAIT: hold the `aes_*` outputs. On `aes_done`:
    - if the FIFO is non-empty, go directly to ISSUE (back-to-back issue);
    - otherwise go to IDLE.
- `aes_done` is ignored outside the WAIT and WAIT_KEY states.
- Reset, asynchronous and allowed mid-operation: empties the FIFO, FSM goes to IDLE, loaded-key-valid clears, and all outputs are 0. An in-flight `aes_build` call is abandoned.
  - Exception: `req_ready` = 1 during reset.

## Timing
- Request accepted at edge N into an empty, idle queue: FSM enters ISSUE at edge N+1, so `aes_start` is high during cycle N+1. WAIT is entered at edge N+2.
- `aes_done` sampled at edge M with a non-empty FIFO: next `aes_start` is high during cycle M+1.
- `aes_func`/`aes_text`/`aes_key` are stable from the `aes_start` cycle until the edge that samples `aes_done`.
- `err_illegal` is high exactly one cycle, the cycle after acceptance.

## Configuration
- Macro: `AES_KEY_AUTOLOAD_EN`.
- Defined:
  - The block tracks `loaded_key` and `loaded_key_valid`.
  - Before issuing a head entry with `FUNC_ENC` or `FUNC_DEC`: if `!loaded_key_valid` or `head.key != loaded_key`, go to ISSUE_KEY instead of ISSUE.
  - ISSUE_KEY drives `aes_func`=`FUNC_KEY`, `aes_key`=head key, `aes_text`=0, and pulses `aes_start`. It does not pop; go to WAIT_KEY.
  - WAIT_KEY, on `aes_done`: update the loaded key and set it valid, then go to ISSUE for the same head.
  - An explicit `FUNC_KEY` request also updates the loaded key, at its `aes_done`.
- Undefined: requests pass through unchanged. ISSUE_KEY, WAIT_KEY and the key registers are absent.

## Structure
- Package `aes_req_pkg` holds:
  - the `FUNC_*` localparams;
  - `req_t` packed struct {func[2:0], text[127:0], key[127:0]};
  - the `aes_state_e` enum.
- Sub-module `aes_req_fifo`:
  - `DEPTH`-entry `req_t` storage with push/pop, pointers and `count`;
  - exposes `empty`, `full` and `head`.
- The FSM and key tracking live in `aes_req_queue`.

Key = 000102030405060708090a0b0c0d0e0f. PT = 00112233445566778899aabbccddeeff. CT = 69c4e0d86a7b0430d8cdb78070b4c55a.

## Test plan
- Reset release, then one `FUNC_KEY` request: `aes_start` high exactly one cycle, one cycle after acceptance, with `aes_func`=3'h2 and `aes_key`=Key. `busy`=1 until `aes_done`.
- Push 4 ENC requests (PT, Key) with `aes_done` held low: `count`=4 and `req_ready`=0. A fifth `req_valid` is not accepted. Each `aes_done` yields the next `aes_start` one cycle later.
- `req_func`=3'h5 with `req_valid`: `err_illegal` pulses once, `count` unchanged, no `aes_start`.
- `AES_KEY_AUTOLOAD_EN` defined, first request DEC (CT, Key):
  - sequence is `aes_func`=2 then `aes_func`=0, two `aes_start` pulses;
  - a second DEC with the same key produces one pulse only;
  - a key change to 2b7e151628aed2a6abf7158809cf4f3c re-inserts the load.
- Reset asserted in WAIT with 2 queued: outputs and `count` are 0 immediately, and a later `aes_done` causes no `aes_start`.
- Simultaneous push and pop at `count`=2: `count` stays 2 and FIFO order is preserved.
